// File: rtl/led_pkg.sv
// Shared definitions for the WS2812B strip path: frame geometry, default
// latch-gap and completion-timeout lengths, and the scheduler state encoding.
package led_pkg;

    // Number of LEDs on the strip and the resulting GRB frame width.
    localparam int LED_NUM_LEDS = 5;

    // Each LED takes 24 bits (8 G, 8 R, 8 B).
    function automatic int frame_width(input int num_leds);
        return 24 * num_leds;
    endfunction

    localparam int LED_FRAME_W = frame_width(LED_NUM_LEDS);

    // 300 us strip latch at 100 MHz; comfortably above the 280 us minimum.
    localparam int LED_GAP_CYCLES = 30000;

    // Longest time a healthy sender may take from start to done.
    localparam int LED_TIMEOUT_CYCLES = 20000;

    // Contested high-priority grants allowed before the low-priority side wins.
    localparam int LED_STARVE_MAX = 4;

    // Width of the shared phase counter; gap and timeout must fit below 2**16.
    localparam int LED_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } sched_state_e;

endpackage

// File: rtl/sched_timer.sv
// Phase counter for the frame scheduler: clear/enable up-counter with a
// terminal-count compare, shared by the completion timeout and the latch gap.
module sched_timer
    import led_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [LED_CNT_W-1:0] tc_i,
    output logic                 at_tc_o
);

    logic [LED_CNT_W-1:0] count_q;

    // Count up while enabled; a clear (or reset) restarts the phase at zero.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign at_tc_o = (count_q == tc_i);

endmodule

// File: rtl/led_frame_scheduler.sv
// Arbitrates the game-engine and attract-pattern frame producers onto the
// single WS2812B sender: grants one request, latches its frame, starts the
// sender, waits for completion (with timeout) and then enforces the strip
// latch gap before the next grant.
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int FRAME_W        = LED_FRAME_W,
    parameter int GAP_CYCLES     = LED_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = LED_TIMEOUT_CYCLES,
    parameter int STARVE_MAX     = LED_STARVE_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic [FRAME_W-1:0] frame0,
    input  logic               req1,
    input  logic [FRAME_W-1:0] frame1,
    output logic               gnt0,
    output logic               gnt1,
    output logic [FRAME_W-1:0] send_frame,
    output logic               send_start,
    input  logic               send_done,
    output logic               busy,
    output logic               owner,
    output logic               timeout_err
);

    // Streak counter only needs to reach STARVE_MAX.
    localparam int STREAK_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(STARVE_MAX);

    // Terminal counts are "last cycle of the phase", hence the minus one.
    localparam logic [LED_CNT_W-1:0] GAP_TC     = LED_CNT_W'(GAP_CYCLES - 1);
    localparam logic [LED_CNT_W-1:0] TIMEOUT_TC = LED_CNT_W'(TIMEOUT_CYCLES - 1);

    sched_state_e state_q, state_d;

    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic [FRAME_W-1:0] send_frame_q, send_frame_d;
    logic               send_start_q, send_start_d;
    logic               busy_q, busy_d;
    logic               owner_q, owner_d;
    logic               timeout_err_q, timeout_err_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic                 grant_fire;
    logic                 pick1;
    logic                 timer_clr;
    logic                 timer_en;
    logic [LED_CNT_W-1:0] tc_value;
    logic                 at_tc;

    // Shared phase counter for WAIT_DONE (timeout) and GAP (latch gap).
    sched_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (timer_clr),
        .en_i    (timer_en),
        .tc_i    (tc_value),
        .at_tc_o (at_tc)
    );

    // Arbitration: req1 wins alone, or when req0 has hogged STARVE_MAX contested grants.
    always_comb begin
        grant_fire = (state_q == ST_IDLE) && (req0 || req1);
        pick1      = req1 && (!req0 || (streak_q == STREAK_SAT));
    end

    // Timer control: restart on entry to a timed phase, count while in one.
    always_comb begin
        tc_value  = (state_q == ST_GAP) ? GAP_TC : TIMEOUT_TC;
        timer_clr = (state_d != state_q) &&
                    ((state_d == ST_WAIT_DONE) || (state_d == ST_GAP));
        timer_en  = (state_q == ST_WAIT_DONE) || (state_q == ST_GAP);
    end

    // State register and registered outputs; reset lands in GAP so the strip
    // always sees a full latch gap before the first frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_GAP;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            send_frame_q  <= '0;
            send_start_q  <= 1'b0;
            busy_q        <= 1'b1;
            owner_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            streak_q      <= '0;
        end else begin
            state_q       <= state_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            send_frame_q  <= send_frame_d;
            send_start_q  <= send_start_d;
            busy_q        <= busy_d;
            owner_q       <= owner_d;
            timeout_err_q <= timeout_err_d;
            streak_q      <= streak_d;
        end
    end

    // Next-state logic; send_done counts only in WAIT_DONE and beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (send_done || at_tc) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (at_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_GAP;
            end
        endcase
    end

    // Output next-values: grant pulses, frame/owner latch, streak, start and error pulses.
    always_comb begin
        gnt0_d        = grant_fire && !pick1;
        gnt1_d        = grant_fire && pick1;
        send_frame_d  = send_frame_q;
        owner_d       = owner_q;
        streak_d      = streak_q;
        send_start_d  = (state_q == ST_GRANT);
        timeout_err_d = (state_q == ST_WAIT_DONE) && at_tc && !send_done;
        busy_d        = (state_d != ST_IDLE);

        if (grant_fire) begin
            owner_d      = pick1;
            send_frame_d = pick1 ? frame1 : frame0;
            if (pick1 || !req1) begin
                streak_d = '0;
            end else if (streak_q != STREAK_SAT) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign send_frame  = send_frame_q;
    assign send_start  = send_start_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Arbitrates two frame producers (game engine and idle/attract pattern source) for the single WS2812B strip sender.
- Latches the granted 120-bit GRB frame, pulses the sender's start, and waits for its completion.
- Enforces the >280 us strip latch (reset-code) gap before the next frame, plus a completion timeout.
- Sits between the game engines and the shift-register/NZR sender chain.

## Interface
- FRAME_W, 120, frame width in bits (24 × number of LEDs)
- GAP_CYCLES, 30000, latch gap length in clk cycles (300 us at 100 MHz); must be < 65536
- TIMEOUT_CYCLES, 20000, max cycles from send_start to send_done; must be < 65536
- STARVE_MAX, 4, consecutive contested req0 grants before req1 is forced
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  high-priority frame request; held until gnt0
- frame0  in  FRAME_W  frame for req0; valid while req0 high
- req1  in  1  low-priority frame request; held until gnt1
- frame1  in  FRAME_W  frame for req1
- gnt0, gnt1  out  1  one-cycle acceptance pulses (never both)
- send_frame  out  FRAME_W  latched frame to sender; stable from grant until next grant
- send_start  out  1  one-cycle start pulse to sender
- send_done  in  1  one-cycle pulse from sender after last bit coded
- busy  out  1  high in every state except IDLE
- owner  out  1  requester of the current/last frame (0 or 1)
- timeout_err  out  1  one-cycle pulse when send_done is missed

## Operation
- States: IDLE, GRANT, START, WAIT_DONE, GAP. All outputs are registered.
- Reset:
  - state = GAP and counter = 0, so the first frame is preceded by a full latch gap.
  - gnt0 = gnt1 = 0, send_start = 0, timeout_err = 0, send_frame = 0, owner = 0, busy = 1, streak = 0.
- IDLE, on any request → GRANT:
  - Asserts the winner's gnt and loads send_frame and owner.
  - Winner is req0 when only req0 is high, req1 when only req1 is high.
  - When both are high: req1 if streak == STARVE_MAX, otherwise req0.
- Streak counter:
  - Increments on a req0 grant made while req1 is high.
  - Clears on any req1 grant and on a req0 grant made while req1 is low.
  - Saturates at STARVE_MAX.
- GRANT → START: asserts send_start. START → WAIT_DONE: loads counter = 0.
- WAIT_DONE:
  - send_done → GAP, counter = 0.
  - counter == TIMEOUT_CYCLES-1 without send_done → GAP and pulse timeout_err.
  - send_done in the same cycle as the timeout boundary counts as done; no error.
- GAP: counter increments; at GAP_CYCLES-1 → IDLE.
- Ignored inputs:
  - send_done outside WAIT_DONE.
  - Requests outside IDLE. Requesters hold req; no queueing.
- Counter: single 16-bit up-counter shared by WAIT_DONE and GAP, no wrap by parameter constraint.
- Reset mid-frame aborts immediately to the reset state; the sender is reset by the same signal.

## Timing
- Request sampled in IDLE at cycle N:
  - gnt and send_frame at N+1.
  - send_start at N+2.
  - WAIT_DONE from N+3.
- send_done sampled at cycle M: GAP from M+1 for exactly GAP_CYCLES cycles; IDLE at M+1+GAP_CYCLES.
- Earliest next grant: M+2+GAP_CYCLES.
- Timeout: timeout_err at S+1+TIMEOUT_CYCLES, where S is the send_start cycle.
- After reset deassertion at cycle R: IDLE at R+GAP_CYCLES; earliest gnt at R+GAP_CYCLES+1.
- busy falls on the cycle the state enters IDLE.

## Structure
- Shared package led_pkg holds:
  - the state enum;
  - FRAME_W derivation (24 × NumLEDs);
  - the default gap and timeout constants, reused by the sender and game engines.
- One sub-module: sched_timer, a clear/enable 16-bit counter with a terminal-count compare input, used for both the timeout and the gap.
- Arbitration and the streak counter stay in the top FSM.

## Test plan
Bench parameters: FRAME_W=120, GAP_CYCLES=10, TIMEOUT_CYCLES=50, STARVE_MAX=4.
- Reset, then hold req0 with frame0=120'hA5… → busy=1 for 10 cycles after reset; gnt0 1 cycle after IDLE; send_frame=frame0; send_start 1 cycle later.
- send_done 20 cycles after send_start with req1 held → GAP 10 cycles; gnt1 exactly 12 cycles after send_done; owner=1.
- req0 and req1 both held continuously, send_done returned after 5 cycles → grant order 0,0,0,0,1,0,0,0,0,1.
- Withhold send_done → timeout_err pulses at send_start+51; GAP follows; a late send_done during GAP is ignored.
- Assert reset in WAIT_DONE → next cycle all outputs at reset values; no gnt before 10 GAP cycles elapse.
- send_done on the exact timeout cycle → no timeout_err; normal GAP.
